// File: rtl/alu_flag_if.sv
// Status/branch bundle between the ALU decoder / control sequencer and the
// flag unit. The master drives ALU status and control requests. The slave
// returns the architectural flags, the carry-in, branch results and stack state.
interface alu_flag_if #(
    parameter int CNT_W = 2
);
    logic             v;
    logic             c;
    logic             n;
    logic             z;
    logic             flag_we;
    logic             int_save;
    logic             int_restore;
    logic             cond_valid;
    logic [3:0]       cond_code;
    logic             err_clr;
    logic [3:0]       flags;
    logic             cin;
    logic             branch_valid;
    logic             branch_taken;
    logic [CNT_W-1:0] stack_count;
    logic             stack_err;

    modport master (
        output v, c, n, z, flag_we, int_save, int_restore,
               cond_valid, cond_code, err_clr,
        input  flags, cin, branch_valid, branch_taken, stack_count, stack_err
    );

    modport slave (
        input  v, c, n, z, flag_we, int_save, int_restore,
               cond_valid, cond_code, err_clr,
        output flags, cin, branch_valid, branch_taken, stack_count, stack_err
    );
endinterface

// File: rtl/alu_flag_unit.sv
// Architectural flag register {N,Z,C,V} with an interrupt flag-save LIFO and
// a one-cycle registered branch-condition evaluator. Branch evaluation sees
// the flags as they will be after this edge, so a capture or restore in the
// same cycle is forwarded into the condition result.
module alu_flag_unit #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    alu_flag_if.slave  bus
);

    // Condition table. f is packed as {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
        logic fn;
        logic fz;
        logic fc;
        logic fv;
        logic r;
        fn = f[3];
        fz = f[2];
        fc = f[1];
        fv = f[0];
        case (code)
            4'd0:    r = 1'b1;
            4'd1:    r = fz;
            4'd2:    r = ~fz;
            4'd3:    r = fc;
            4'd4:    r = ~fc;
            4'd5:    r = fn;
            4'd6:    r = ~fn;
            4'd7:    r = fv;
            4'd8:    r = ~fv;
            4'd9:    r = fc & ~fz;
            4'd10:   r = ~fc | fz;
            4'd11:   r = (fn == fv);
            4'd12:   r = (fn != fv);
            4'd13:   r = ~fz & (fn == fv);
            4'd14:   r = fz | (fn != fv);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [3:0]       flags_reg;
    logic [3:0]       flags_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [3:0]       stack_reg [DEPTH];
    logic [3:0]       stack_top;
    logic             err_reg;
    logic             err_next;
    logic             bvalid_reg;
    logic             btaken_reg;
    logic             btaken_next;

    logic             stack_full;
    logic             stack_empty;
    logic             req_conflict;
    logic             do_push;
    logic             do_pop;
    logic             err_set;

    // Stack occupancy and which of push/pop actually happens this cycle.
    // A simultaneous save and restore is treated as an error and neither
    // operation is performed.
    always_comb begin
        stack_full   = (count_reg == CNT_W'(DEPTH));
        stack_empty  = (count_reg == '0);
        req_conflict = bus.int_save & bus.int_restore;
        do_push      = bus.int_save & ~bus.int_restore & ~stack_full;
        do_pop       = bus.int_restore & ~bus.int_save & ~stack_empty;
        err_set      = req_conflict
                     | (bus.int_save & ~bus.int_restore & stack_full)
                     | (bus.int_restore & ~bus.int_save & stack_empty);
    end

    // Select the most recently pushed entry. The entry at index count-1 is the top.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_reg == CNT_W'(i + 1)) begin
                stack_top = stack_reg[i];
            end
        end
    end

    // Next flags: restore beats capture, and capture beats hold. Also compute
    // the next occupancy, the sticky error and the forwarded branch result.
    always_comb begin
        flags_next = flags_reg;
        if (do_pop) begin
            flags_next = stack_top;
        end else if (bus.flag_we) begin
            flags_next = {bus.n, bus.z, bus.c, bus.v};
        end

        count_next = count_reg;
        if (do_push) begin
            count_next = count_reg + 1'b1;
        end else if (do_pop) begin
            count_next = count_reg - 1'b1;
        end

        err_next = err_reg;
        if (err_set) begin
            err_next = 1'b1;
        end else if (bus.err_clr) begin
            err_next = 1'b0;
        end

        btaken_next = bus.cond_valid & cond_eval(bus.cond_code, flags_next);
    end

    // Architectural state: flags, occupancy, error and branch result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_reg  <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
            bvalid_reg <= 1'b0;
            btaken_reg <= 1'b0;
        end else begin
            flags_reg  <= flags_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
            bvalid_reg <= bus.cond_valid;
            btaken_reg <= btaken_next;
        end
    end

    // Save-stack storage. A push writes the flags held before this edge into
    // the first free slot. A same-edge capture lands only in the flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_reg[i] <= '0;
            end
        end else if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count_reg == CNT_W'(i)) begin
                    stack_reg[i] <= flags_reg;
                end
            end
        end
    end

    assign bus.flags        = flags_reg;
    assign bus.cin          = flags_reg[1];
    assign bus.branch_valid = bvalid_reg;
    assign bus.branch_taken = btaken_reg;
    assign bus.stack_count  = count_reg;
    assign bus.stack_err    = err_reg;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit. Branch responses are checked by a
// scoreboard queue drained by a monitor on the falling edge. Flag and stack
// state are checked directly one step after each rising edge.
module tb_alu_flag_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   nresp;
    logic exp_q [$];

    alu_flag_if #(.CNT_W(2)) bus ();

    alu_flag_unit #(.DEPTH(2), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected branch result, written directly from the condition table.
    function automatic logic ref_cond(input int code, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        if (code == 0)  return 1'b1;
        if (code == 1)  return z;
        if (code == 2)  return !z;
        if (code == 3)  return c;
        if (code == 4)  return !c;
        if (code == 5)  return n;
        if (code == 6)  return !n;
        if (code == 7)  return v;
        if (code == 8)  return !v;
        if (code == 9)  return c && !z;
        if (code == 10) return !c || z;
        if (code == 11) return n == v;
        if (code == 12) return n != v;
        if (code == 13) return !z && (n == v);
        if (code == 14) return z || (n != v);
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic idle_inputs();
        bus.v           = 1'b0;
        bus.c           = 1'b0;
        bus.n           = 1'b0;
        bus.z           = 1'b0;
        bus.flag_we     = 1'b0;
        bus.int_save    = 1'b0;
        bus.int_restore = 1'b0;
        bus.cond_valid  = 1'b0;
        bus.cond_code   = 4'd0;
        bus.err_clr     = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {bus.n, bus.z, bus.c, bus.v} = f;
        bus.flag_we = 1'b1;
    endtask

    task automatic branch(input logic [3:0] code, input logic exp);
        bus.cond_valid = 1'b1;
        bus.cond_code  = code;
        exp_q.push_back(exp);
    endtask

    // Apply the currently driven inputs for one edge, then return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Monitor: every presented branch result must match the oldest expectation.
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            if (bus.branch_valid === 1'b1) begin
                total++;
                nresp++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL branch_unexpected actual=%0b required=none", bus.branch_taken);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.branch_taken !== e) begin
                        bad++;
                        $display("FAIL branch_%0d actual=%0b required=%0b", nresp, bus.branch_taken, e);
                    end else begin
                        $display("branch %0d taken=%0b ok", nresp, bus.branch_taken);
                    end
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        nresp = 0;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", bus.flags, 4'h0);
        chk("reset_count", bus.stack_count, 2'd0);
        chk("reset_bvalid", bus.branch_valid, 1'b0);
        chk("reset_err", bus.stack_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Flag capture
        set_flags(4'b1010);
        tick();
        chk("capture_flags", bus.flags, 4'b1010);
        chk("capture_cin", bus.cin, 1'b1);

        // Forwarding: Z written in the same cycle as an EQ request
        set_flags(4'b0100);
        branch(4'd1, 1'b1);
        tick();
        chk("fwd_flags", bus.flags, 4'b0100);
        branch(4'd2, 1'b0);
        tick();
        branch(4'd9, 1'b0);
        tick();
        branch(4'd10, 1'b1);
        tick();

        // Nesting: save 1000, capture 0100, save, then two restores
        set_flags(4'b1000);
        tick();
        bus.int_save = 1'b1;
        tick();
        chk("nest_count1", bus.stack_count, 2'd1);
        set_flags(4'b0100);
        tick();
        bus.int_save = 1'b1;
        tick();
        chk("nest_count2", bus.stack_count, 2'd2);
        set_flags(4'b0011);
        tick();
        chk("nest_pre", bus.flags, 4'b0011);
        bus.int_restore = 1'b1;
        set_flags(4'b1111);        // ignored: restore wins
        branch(4'd1, 1'b1);        // EQ on the restored 0100
        tick();
        chk("nest_pop1_flags", bus.flags, 4'b0100);
        chk("nest_pop1_count", bus.stack_count, 2'd1);
        bus.int_restore = 1'b1;
        tick();
        chk("nest_pop2_flags", bus.flags, 4'b1000);
        chk("nest_pop2_count", bus.stack_count, 2'd0);
        chk("nest_err", bus.stack_err, 1'b0);

        // Stack errors: overflow, conflict, set-wins-over-clear, underflow
        set_flags(4'b0010);
        tick();
        bus.int_save = 1'b1;
        tick();
        set_flags(4'b0101);
        tick();
        bus.int_save = 1'b1;
        tick();
        chk("ovf_pre_count", bus.stack_count, 2'd2);
        bus.int_save = 1'b1;
        set_flags(4'b0001);
        tick();
        chk("ovf_count", bus.stack_count, 2'd2);
        chk("ovf_err", bus.stack_err, 1'b1);
        chk("ovf_flags", bus.flags, 4'b0001);
        bus.err_clr = 1'b1;
        tick();
        chk("clr_err", bus.stack_err, 1'b0);
        bus.int_save    = 1'b1;
        bus.int_restore = 1'b1;
        set_flags(4'b0110);
        tick();
        chk("conf_count", bus.stack_count, 2'd2);
        chk("conf_err", bus.stack_err, 1'b1);
        chk("conf_flags", bus.flags, 4'b0110);
        bus.err_clr = 1'b1;
        tick();
        chk("clr_err2", bus.stack_err, 1'b0);
        bus.err_clr  = 1'b1;
        bus.int_save = 1'b1;       // full: set beats clear
        tick();
        chk("setwins_err", bus.stack_err, 1'b1);
        bus.err_clr = 1'b1;
        tick();
        bus.int_restore = 1'b1;
        tick();
        chk("pop_a_flags", bus.flags, 4'b0101);
        bus.int_restore = 1'b1;
        tick();
        chk("pop_b_flags", bus.flags, 4'b0010);
        chk("pop_b_count", bus.stack_count, 2'd0);
        chk("pop_b_err", bus.stack_err, 1'b0);
        bus.int_restore = 1'b1;
        set_flags(4'b1001);        // empty: capture applies
        tick();
        chk("unf_err", bus.stack_err, 1'b1);
        chk("unf_flags", bus.flags, 4'b1001);
        chk("unf_count", bus.stack_count, 2'd0);
        bus.err_clr = 1'b1;
        tick();
        chk("unf_clr", bus.stack_err, 1'b0);

        // Full sweep: every code against every forwarded flag value
        for (int f = 0; f < 16; f++) begin
            for (int code = 0; code < 16; code++) begin
                set_flags(4'(f));
                branch(4'(code), ref_cond(code, 4'(f)));
                tick();
            end
        end
        tick();
        tick();

        // Asynchronous reset mid-stream with two entries stacked
        set_flags(4'b1100);
        tick();
        bus.int_save = 1'b1;
        tick();
        bus.int_save = 1'b1;
        tick();
        bus.cond_valid = 1'b1;     // result is reset away before the monitor samples it
        bus.cond_code  = 4'd0;
        tick();
        chk("pre_rst_count", bus.stack_count, 2'd2);
        chk("pre_rst_bvalid", bus.branch_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_flags", bus.flags, 4'h0);
        chk("async_count", bus.stack_count, 2'd0);
        chk("async_bvalid", bus.branch_valid, 1'b0);
        chk("async_cin", bus.cin, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.int_restore = 1'b1;    // stack was emptied by reset
        tick();
        chk("post_rst_err", bus.stack_err, 1'b1);
        chk("post_rst_flags", bus.flags, 4'h0);
        tick();
        tick();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
